// File: rtl/johnson_seq_ctrl.sv
// Run-controlled multi-phase sequencer: a Johnson register stepped by a prescaler,
// counting revolutions, with one-hot phase decode and a sticky illegal-code flag.
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   run_len,
  input  logic [DIV_W-1:0]   div,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   johnson,
  output logic [2*WIDTH-1:0] phase,
  output logic               err
);

  localparam int KW = $clog2(2*WIDTH) + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_johnson, w_johnson_nxt;
  logic [DIV_W-1:0]   r_presc, w_presc_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic [CNT_W-1:0]   r_rev, w_rev_nxt;
  logic [CNT_W-1:0]   r_len, w_len_nxt;
  logic               r_err, w_err_nxt;
  logic               r_done, w_done_nxt;

  logic               w_tick;
  logic               w_wrap;
  logic               w_finish;
  logic               w_legal;
  logic [CNT_W-1:0]   w_rev_inc;
  logic [WIDTH-1:0]   w_step;
  logic [KW-1:0]      w_pop;
  logic [KW-1:0]      w_trans;
  logic [KW-1:0]      w_k;

  assign w_tick    = (r_presc == r_div);
  assign w_step    = {r_johnson[WIDTH-2:0], ~r_johnson[WIDTH-1]};
  assign w_wrap    = w_tick && (r_johnson == {1'b1, {(WIDTH-1){1'b0}}});
  assign w_rev_inc = r_rev + 1'b1;
  assign w_finish  = w_wrap && (r_len != '0) && (w_rev_inc == r_len);

  // Popcount drives the phase index; adjacent-bit transition count drives legality.
  always_comb begin
    w_pop   = '0;
    w_trans = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + KW'(r_johnson[i]);
    end
    for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
      w_trans = w_trans + KW'(r_johnson[i] ^ r_johnson[i+1]);
    end
  end

  assign w_legal = (w_trans <= KW'(1));
  assign w_k     = r_johnson[WIDTH-1] ? (KW'(2*WIDTH) - w_pop) : w_pop;

  always_comb begin
    w_state_nxt   = r_state;
    w_johnson_nxt = r_johnson;
    w_presc_nxt   = r_presc;
    w_div_nxt     = r_div;
    w_rev_nxt     = r_rev;
    w_len_nxt     = r_len;
    w_err_nxt     = r_err;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state_nxt   = S_RUN;
          w_johnson_nxt = '0;
          w_presc_nxt   = '0;
          w_rev_nxt     = '0;
          w_len_nxt     = run_len;
          w_div_nxt     = div;
          w_err_nxt     = 1'b0;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt   = S_IDLE;
          w_johnson_nxt = '0;
        end else begin
          w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
          if (!w_legal) begin
            // Recovery zeroes the register but keeps the prescaler cadence running.
            w_err_nxt     = 1'b1;
            w_johnson_nxt = '0;
          end else if (w_tick) begin
            w_johnson_nxt = w_step;
            if (w_wrap) w_rev_nxt = w_rev_inc;
            if (w_finish) begin
              w_state_nxt   = S_IDLE;
              w_johnson_nxt = '0;
              w_done_nxt    = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_johnson <= '0;
      r_presc   <= '0;
      r_div     <= '0;
      r_rev     <= '0;
      r_len     <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_johnson <= w_johnson_nxt;
      r_presc   <= w_presc_nxt;
      r_div     <= w_div_nxt;
      r_rev     <= w_rev_nxt;
      r_len     <= w_len_nxt;
      r_err     <= w_err_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = r_done;
  assign johnson = r_johnson;
  assign err     = r_err;
  assign phase   = busy ? ({{(2*WIDTH-1){1'b0}}, 1'b1} << w_k) : '0;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl: directed scenarios plus random commands,
// compared every cycle against a step-index reference model.
module tb_johnson_seq_ctrl;

  localparam int W   = 4;
  localparam int CW  = 8;
  localparam int DW  = 8;
  localparam int NST = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop;
  logic [CW-1:0] run_len;
  logic [DW-1:0] div;
  logic          busy, done, err;
  logic [W-1:0]  johnson;
  logic [NST-1:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position in the revolution, prescaler count, revolutions.
  logic m_busy, m_done, m_err, m_inject;
  int   m_s, m_p, m_rev, m_len, m_div;
  int   busy_cnt, done_cnt;

  johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW), .DIV_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .run_len(run_len), .div(div), .busy(busy), .done(done),
    .johnson(johnson), .phase(phase), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Johnson value at step s: s ones filling from the LSB, then zeros filling from the LSB.
  function automatic logic [W-1:0] jval(input int s);
    int v;
    if (s <= W) v = (1 << s) - 1;
    else        v = ((1 << W) - 1) << (s - W);
    return W'(v & ((1 << W) - 1));
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_inject = 0;
    m_s = 0; m_p = 0; m_rev = 0; m_len = 0; m_div = 0;
  endtask

  task automatic model_step();
    m_done = 0;
    if (!m_busy) begin
      if (start && !stop) begin
        m_busy = 1; m_s = 0; m_p = 0; m_rev = 0;
        m_len = int'(run_len); m_div = int'(div); m_err = 0;
      end
    end else if (stop) begin
      m_busy = 0; m_s = 0;
    end else if (m_inject) begin
      m_err = 1; m_s = 0;
      m_p = (m_p == m_div) ? 0 : m_p + 1;
    end else if (m_p == m_div) begin
      m_p = 0;
      if (m_s == NST - 1) begin
        m_s = 0;
        m_rev = (m_rev + 1) % (1 << CW);
        if (m_len != 0 && m_rev == m_len) begin
          m_done = 1; m_busy = 0;
        end
      end else begin
        m_s = m_s + 1;
      end
    end else begin
      m_p = m_p + 1;
    end
    m_inject = 0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".err"},  32'(err),  32'(m_err));
    chk({tag, ".johnson"}, 32'(johnson), m_busy ? 32'(jval(m_s)) : 32'd0);
    chk({tag, ".phase"},   32'(phase),   m_busy ? (32'd1 << m_s) : 32'd0);
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic step_cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    @(negedge clk);
  endtask

  task automatic pulse_start(input int len, input int dv, input string tag);
    run_len = CW'(len); div = DW'(dv); start = 1;
    step_cycle(tag);
    start = 0;
  endtask

  initial begin
    model_reset();
    start = 0; stop = 0; run_len = '0; div = '0;
    rst_n = 1;
    #2 rst_n = 0;
    #1 compare_all("reset");
    @(negedge clk);
    rst_n = 1;
    step_cycle("idle");

    // Basic run: div=0, two revolutions.
    busy_cnt = 0; done_cnt = 0;
    pulse_start(2, 0, "basic");
    for (int i = 0; i < 20; i++) step_cycle("basic");
    chk("basic.busy_cycles", busy_cnt, 16);
    chk("basic.done_count", done_cnt, 1);

    // Prescaler: div=2, one revolution.
    busy_cnt = 0; done_cnt = 0;
    pulse_start(1, 2, "presc");
    for (int i = 0; i < 28; i++) step_cycle("presc");
    chk("presc.busy_cycles", busy_cnt, 24);
    chk("presc.done_count", done_cnt, 1);

    // Stop at 0111 has priority and produces no done.
    done_cnt = 0;
    pulse_start(1, 0, "stop");
    for (int i = 0; i < 10 && !(m_busy && m_s == 3); i++) step_cycle("stop.wait");
    chk("stop.at_0111", 32'(johnson), 32'h7);
    stop = 1;
    step_cycle("stop");
    stop = 0;
    for (int i = 0; i < 3; i++) step_cycle("stop.after");
    chk("stop.no_done", done_cnt, 0);

    // start with stop in IDLE stays IDLE.
    start = 1; stop = 1; run_len = 8'd1;
    step_cycle("startstop");
    start = 0; stop = 0;
    step_cycle("startstop.after");

    // Free-run with ignored start pulses, then stop.
    done_cnt = 0;
    pulse_start(0, 0, "free");
    for (int i = 0; i < 40; i++) begin
      start = ($urandom_range(0, 3) == 0);
      run_len = CW'($urandom_range(1, 3));
      div = DW'($urandom_range(0, 3));
      step_cycle("free");
    end
    start = 0;
    chk("free.no_done", done_cnt, 0);
    stop = 1;
    step_cycle("free.stop");
    stop = 0;

    // Illegal code injection while running.
    pulse_start(0, 0, "illegal");
    for (int i = 0; i < 2; i++) step_cycle("illegal.pre");
    force dut.r_johnson = 4'b0110;
    #3 release dut.r_johnson;
    m_inject = 1;
    step_cycle("illegal.hit");
    for (int i = 0; i < 12; i++) step_cycle("illegal.post");
    stop = 1;
    step_cycle("illegal.stop");
    stop = 0;
    chk("illegal.err_sticky_idle", 32'(err), 32'd1);
    pulse_start(1, 0, "illegal.restart");
    for (int i = 0; i < 10; i++) step_cycle("illegal.restart");

    // Asynchronous reset mid-run at 1100.
    pulse_start(0, 1, "rstmid");
    for (int i = 0; i < 30 && !(m_busy && m_s == 6); i++) step_cycle("rstmid.wait");
    chk("rstmid.at_1100", 32'(johnson), 32'hC);
    #2 rst_n = 0;
    #1;
    model_reset();
    compare_all("rstmid.async");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) step_cycle("rstmid.idle");

    // Random command stream.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 15) == 0);
      stop = ($urandom_range(0, 63) == 0);
      run_len = CW'($urandom_range(0, 3));
      div = DW'($urandom_range(0, 3));
      step_cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
- Run-controlled multi-phase timing sequencer built around a Johnson shift register.
- Accepts start/stop commands, paces stepping with a programmable prescaler, and counts completed Johnson revolutions.
- Drives a one-hot phase bus for downstream strobes and monitors the register for illegal codes.
- Sits between control logic and phase-strobe consumers, which see only busy/done/phase.

Parameters:
- WIDTH, 4, Johnson stages (2*WIDTH states); legal range >=2.
- CNT_W, 8, revolution counter / run_len width.
- DIV_W, 8, prescaler width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  start request, sampled each clk.
- stop  input  1  abort request, sampled each clk.
- run_len  input  CNT_W  revolutions to run; 0 = free-run until stop; sampled on accepted start.
- div  input  DIV_W  step every div+1 clocks; sampled on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse on normal completion.
- johnson  output  WIDTH  current Johnson register.
- phase  output  2*WIDTH  one-hot phase decode; all-zero when busy=0.
- err  output  1  sticky illegal-state flag.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: busy=0, done=0, johnson=0, phase=0, err=0.
  - Internal: prescaler=0, rev counter=0, state=IDLE.
  - Reset takes effect immediately, including mid-run; no done is generated.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 and stop=0 → RUN on next edge: busy=1, johnson=0, prescaler=0, rev=0, run_len/div latched, err cleared.
  - start=1 with stop=1 → stop wins; stay IDLE.
- RUN, stepping:
  - tick = (prescaler==div_latched). On tick: prescaler←0 and johnson←{johnson[WIDTH-2:0], ~johnson[WIDTH-1]}. Otherwise prescaler←prescaler+1.
  - Step sequence (W=4): 0000→0001→0011→0111→1111→1110→1100→1000→0000.
- RUN, revolution counting:
  - A revolution completes on a tick that moves johnson from {1,0..0} to all-zero; rev←rev+1, wrapping mod 2^CNT_W.
  - If run_len_latched≠0 and rev+1==run_len_latched on that tick: done=1 for one cycle, busy=0, state=IDLE, johnson=0.
  - run_len_latched=0: never completes; only stop exits.
- RUN, other commands:
  - start is ignored while in RUN.
  - stop=1 in RUN → IDLE next edge: busy=0, johnson=0, no done. stop has priority over a completing tick in the same cycle.
- Phase decode (combinational from johnson, gated by busy):
  - k = popcount(johnson) when MSB=0; k = 2*WIDTH − popcount(johnson) when MSB=1.
  - phase = 1<<k.
- Legality check:
  - A code is legal iff there is at most one bit transition between adjacent bits, MSB to LSB, excluding wrap.
  - If johnson is illegal while in RUN: err←1 (sticky) and johnson←0 on the next edge. Run continues; rev is unchanged.
  - err clears only on reset or an accepted start.
- Latency:
  - Accepted start at edge E0 → busy=1 after E0.
  - First step occurs at edge E0+div+1.
  - A full run lasts run_len*2*WIDTH*(div+1) cycles of busy.

Test Plan:
- Basic run: WIDTH=4, div=0, run_len=2, pulse start → busy high exactly 16 cycles; johnson follows 0000,0001,0011,0111,1111,1110,1100,1000 twice; phase walks bit0..bit7; done pulses once as busy falls.
- Prescaler: div=2, run_len=1 → each johnson value held 3 cycles; busy high 24 cycles; single done.
- Stop and priority:
  - stop asserted at johnson=0111 → busy=0 and johnson=0 next cycle; no done.
  - start+stop together in IDLE → stays IDLE.
- Free-run and command ignore: run_len=0 → run 40 cycles with no done; start pulses mid-run do not restart (johnson sequence unbroken); stop ends the run.
- Illegal code: force johnson=0110 for one cycle in RUN → err=1, johnson=0000 next cycle, stepping resumes; err stays 1 until next start.
- Reset mid-run: rst_n low at johnson=1100 → all outputs 0 immediately (asynchronously); after release, IDLE until start.
